// File: rtl/odd_signal_pkg.sv
// Shared types for the odd-parity frame controller and its nibble datapath.
package odd_signal_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/odd_signal.sv
// Four-input odd-parity cell: y is high when an odd number of inputs are high.
module odd_signal (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);

    assign y = a ^ b ^ c ^ d;

endmodule

// File: rtl/odd_parity_frame_ctrl.sv
// Frame sequencer: feeds one nibble per accepted beat through odd_signal and
// folds the per-nibble parity into a frame result checked against exp_par.
module odd_parity_frame_ctrl
    import odd_signal_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int CNT_W   = $clog2(NIBBLES + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                exp_par,
    input  logic                abort,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NIBBLE_W-1:0] in_nibble,
    output logic                busy,
    output logic [CNT_W-1:0]    nib_cnt,
    output logic                par_out,
    output logic                par_err,
    output logic                done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

    ctrl_state_t state;
    ctrl_state_t state_nxt;

    logic nib_y;
    logic acc;
    logic exp_par_q;
    logic start_acc;
    logic beat_acc;

    odd_signal u_odd_signal (
        .a (in_nibble[0]),
        .b (in_nibble[1]),
        .c (in_nibble[2]),
        .d (in_nibble[3]),
        .y (nib_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort is tested before the beat so a same-cycle accept is never counted.
    always_comb begin
        state_nxt = state;
        start_acc = 1'b0;
        beat_acc  = 1'b0;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (in_valid) begin
                    beat_acc = 1'b1;
                    if (nib_cnt == LAST_IDX) begin
                        state_nxt = CHECK;
                    end
                end
            end
            CHECK: begin
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Results persist after DONE; only an accepted start clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 1'b0;
            exp_par_q <= 1'b0;
            nib_cnt   <= '0;
            par_out   <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            if (start_acc) begin
                acc       <= 1'b0;
                exp_par_q <= exp_par;
                nib_cnt   <= '0;
                par_out   <= 1'b0;
                par_err   <= 1'b0;
            end else if (beat_acc) begin
                acc     <= acc ^ nib_y;
                nib_cnt <= nib_cnt + 1'b1;
            end else if (state == CHECK) begin
                par_out <= acc;
                par_err <= acc ^ exp_par_q;
            end
        end
    end

endmodule

// File: tb/tb_odd_parity_frame_ctrl.sv
// Scoreboarded bench: stimulus queues expected frame results, a done-driven
// monitor pops and compares them.
module tb_odd_parity_frame_ctrl;

    localparam int NIBBLES = 4;
    localparam int CNT_W   = $clog2(NIBBLES + 1);

    typedef struct {
        logic par;
        logic err;
        int   cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             exp_par;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_nibble;
    logic             busy;
    logic [CNT_W-1:0] nib_cnt;
    logic             par_out;
    logic             par_err;
    logic             done;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [3:0] frame_nibs [NIBBLES];
    bit   pre_started = 1'b0;

    odd_parity_frame_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .exp_par   (exp_par),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_nibble (in_nibble),
        .busy      (busy),
        .nib_cnt   (nib_cnt),
        .par_out   (par_out),
        .par_err   (par_err),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued frame result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_done actual=1 expected=0 at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("mon_par_out", par_out, e.par);
                checkOutput("mon_par_err", par_err, e.err);
                checkOutput("mon_nib_cnt", nib_cnt, e.cnt);
            end
        end
    end

    // Runs one frame from a negedge drive point. gap_max<0 gives gaps 0,1,2,...;
    // abort_at>=0 aborts on that beat; chain_exp>=0 raises start on the done cycle.
    task automatic applyStimulus(input int exp_v, input int gap_max, input int abort_at,
                                 input int chain_exp, input bit noise);
        int   ones;
        int   cycles;
        int   gap;
        logic par;
        logic expb;
        expb = (exp_v != 0);
        ones = 0;
        for (int i = 0; i < NIBBLES; i++) ones += $countones(frame_nibs[i]);
        par = logic'(ones % 2);
        if (!pre_started) begin
            start   = 1'b1;
            exp_par = expb;
            @(negedge clk);
            start = 1'b0;
        end
        pre_started = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_ready", in_ready, 1);
        checkOutput("start_cnt", nib_cnt, 0);
        if (abort_at < 0) exp_q.push_back('{par, par ^ expb, NIBBLES});
        for (int i = 0; i < NIBBLES; i++) begin
            gap = (gap_max < 0) ? i : int'($urandom_range(0, gap_max));
            repeat (gap) begin
                in_valid = 1'b0;
                start    = noise ? 1'($urandom % 2) : 1'b0;
                @(negedge clk);
            end
            in_valid  = 1'b1;
            in_nibble = frame_nibs[i];
            start     = noise ? 1'($urandom % 2) : 1'b0;
            abort     = (i == abort_at);
            @(negedge clk);
            if (i == abort_at) begin
                in_valid = 1'b0;
                abort    = 1'b0;
                start    = 1'b0;
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_cnt", nib_cnt, i);
                checkOutput("abort_par_out", par_out, 0);
                checkOutput("abort_par_err", par_err, 0);
                repeat (3) @(negedge clk);
                return;
            end
        end
        in_valid = 1'b0;
        start    = noise ? 1'($urandom % 2) : 1'b0;
        cycles   = 1;
        while (!done && cycles < 8) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
        checkOutput("done_latency", cycles, 2);
        start = (chain_exp >= 0);
        if (chain_exp >= 0) exp_par = (chain_exp != 0);
        @(negedge clk);
        checkOutput("done_width", done, 0);
        checkOutput("post_busy", busy, 0);
        checkOutput("hold_par_out", par_out, par);
        checkOutput("hold_par_err", par_err, par ^ expb);
        checkOutput("hold_cnt", nib_cnt, NIBBLES);
        if (chain_exp >= 0) begin
            @(negedge clk);
            start = 1'b0;
            checkOutput("chain_busy", busy, 1);
            checkOutput("chain_clear_par", par_out, 0);
            checkOutput("chain_clear_cnt", nib_cnt, 0);
            pre_started = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int exp_v;
        int next_exp;
        int abort_at;
        int chain;
        rst_n     = 1'b0;
        start     = 1'b0;
        exp_par   = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_nibble = 4'h0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", in_ready, 0);
        checkOutput("rst_cnt", nib_cnt, 0);
        checkOutput("rst_par_out", par_out, 0);
        checkOutput("rst_par_err", par_err, 0);
        checkOutput("rst_done", done, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset in the middle of a frame after two beats.
        start   = 1'b1;
        exp_par = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        in_valid  = 1'b1;
        in_nibble = 4'hF;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        checkOutput("mid_cnt_before", nib_cnt, 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ready", in_ready, 0);
        checkOutput("mid_rst_cnt", nib_cnt, 0);
        checkOutput("mid_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        frame_nibs = '{4'h1, 4'h3, 4'h7, 4'hF};
        applyStimulus(0, 0, -1, -1, 1'b0);
        applyStimulus(1, 0, -1, -1, 1'b0);
        frame_nibs = '{4'h1, 4'h0, 4'h0, 4'h0};
        applyStimulus(1, 0, -1, -1, 1'b0);

        // Valid asserted while idle must not be accepted.
        in_valid  = 1'b1;
        in_nibble = 4'hB;
        repeat (3) begin
            @(negedge clk);
            checkOutput("idle_ready", in_ready, 0);
            checkOutput("idle_cnt_hold", nib_cnt, NIBBLES);
        end
        frame_nibs = '{4'h8, 4'hE, 4'h5, 4'h6};
        applyStimulus(0, -1, -1, 1, 1'b0);
        frame_nibs = '{4'h1, 4'h3, 4'h7, 4'hF};
        applyStimulus(1, 1, -1, -1, 1'b1);
        frame_nibs = '{4'h9, 4'h2, 4'h4, 4'hC};
        applyStimulus(0, 0, 2, -1, 1'b1);

        next_exp = int'($urandom % 2);
        for (int f = 0; f < 24; f++) begin
            for (int i = 0; i < NIBBLES; i++) frame_nibs[i] = 4'($urandom);
            exp_v    = next_exp;
            next_exp = int'($urandom % 2);
            abort_at = ($urandom % 5 == 0) ? int'($urandom_range(0, NIBBLES - 1)) : -1;
            chain    = (abort_at < 0 && $urandom % 3 == 0) ? next_exp : -1;
            applyStimulus(exp_v, 2, abort_at, chain, 1'b1);
        end
        if (pre_started) begin
            frame_nibs = '{4'h7, 4'h7, 4'h7, 4'h6};
            applyStimulus(next_exp, 0, -1, -1, 1'b0);
        end

        repeat (4) @(negedge clk);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
